// File: rtl/jlsemi_util_clkdiv_ratio_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jlsemi_util_clkdiv_pkg
//  Description : Shared definitions for the clock-divider ratio controller:
//                state encoding, minimum legal divide ratio and parameter
//                legality helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package jlsemi_util_clkdiv_pkg;

    // Smallest ratio the odd/even divider can produce.
    localparam int MIN_DIV = 2;

    // Controller state encoding. Kept as plain constants so that legacy
    // netlists and scripts that probe the raw state vector keep working.
    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t c_ST_INIT   = 3'd0;
    localparam state_t c_ST_IDLE   = 3'd1;
    localparam state_t c_ST_DRAIN  = 3'd2;
    localparam state_t c_ST_GATE   = 3'd3;
    localparam state_t c_ST_LOAD   = 3'd4;
    localparam state_t c_ST_SETTLE = 3'd5;
    localparam state_t c_ST_DONE   = 3'd6;

    // The power-on ratio must be a ratio the divider can run and must fit
    // in the ratio field.
    function automatic bit div_default_ok(input int div_default, input int div_w);
        return (div_default >= MIN_DIV) && (div_default < (1 << div_w));
    endfunction

    // Gate-off and settle windows need at least one cycle each so that the
    // divider never sees a load while its output clock is still enabled.
    function automatic bit cycle_cnt_ok(input int cyc);
        return (cyc >= 1);
    endfunction

    // Width needed to count 0..max_cyc-1.
    function automatic int cnt_width(input int max_cyc);
        return (max_cyc > 1) ? $clog2(max_cyc) : 1;
    endfunction

endpackage : jlsemi_util_clkdiv_pkg
`default_nettype wire

// File: rtl/jlsemi_util_clkdiv_ratio_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : jlsemi_util_clkdiv_ratio_ctrl_if
//  Description : Four-phase ratio-change request channel. The master raises
//                cfg_req with cfg_div; the controller answers with cfg_ack
//                (and cfg_err) and holds them until cfg_req falls.
//  Revision    : 1.0 - initial release
// ============================================================================
interface jlsemi_util_clkdiv_ratio_ctrl_if #(
    parameter int DIV_W = 8
);
    logic             cfg_req;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ack;
    logic             cfg_err;

    // Requesting side (software bridge / testbench).
    modport master (
        output cfg_req,
        output cfg_div,
        input  cfg_ack,
        input  cfg_err
    );

    // Controller side.
    modport slave (
        input  cfg_req,
        input  cfg_div,
        output cfg_ack,
        output cfg_err
    );

endinterface : jlsemi_util_clkdiv_ratio_ctrl_if
`default_nettype wire

// File: rtl/jlsemi_util_clkdiv_ratio_ctrl_phase_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : jlsemi_util_clkdiv_phase_cnt
//  Description : Model of the divider phase. Counts 0..ratio-1 while the
//                output clock is enabled and parks at 0 while it is gated or
//                while the divider is being soft-reset. wrap flags the last
//                phase of a divided-clock period.
//  Revision    : 1.0 - initial release
// ============================================================================
module jlsemi_util_clkdiv_phase_cnt
    import jlsemi_util_clkdiv_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk_in_pre,
    input  logic             rstn_out,
    input  logic             en,
    input  logic [DIV_W-1:0] ratio,
    input  logic             clr,
    output logic [DIV_W-1:0] phase,
    output logic             wrap
);

    logic [DIV_W-1:0] r_phase;
    logic             w_last;

    // Last phase of the current divided-clock period.
    assign w_last = (r_phase == (ratio - DIV_W'(1)));

    // Phase advances only while the clock is running; a gated or cleared
    // divider restarts its period from phase 0.
    always_ff @(posedge clk_in_pre or negedge rstn_out) begin
        if (!rstn_out) begin
            r_phase <= '0;
        end else if (clr || !en) begin
            r_phase <= '0;
        end else if (w_last) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + DIV_W'(1);
        end
    end

    assign phase = r_phase;
    assign wrap  = en && w_last;

endmodule : jlsemi_util_clkdiv_phase_cnt
`default_nettype wire

// File: rtl/jlsemi_util_clkdiv_ratio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : jlsemi_util_clkdiv_ratio_ctrl
//  Description : Runtime divide-ratio controller. Accepts ratio changes on a
//                four-phase handshake, waits for the divided-clock period
//                boundary, gates the output clock, soft-resets the divider,
//                loads the new ratio, settles and re-enables the clock.
//                Same-ratio and illegal (<2) requests are acknowledged
//                immediately without touching the clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module jlsemi_util_clkdiv_ratio_ctrl
    import jlsemi_util_clkdiv_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = 5,
    parameter int GATE_CYC    = 2,
    parameter int SETTLE_CYC  = 4
) (
    input  logic                             clk_in_pre,
    input  logic                             rstn_out,
    jlsemi_util_clkdiv_ratio_ctrl_if.slave   cfg_if,
    output logic [DIV_W-1:0]                 div_ratio,
    output logic                             div_rstn,
    output logic                             clk_gate_en,
    output logic [DIV_W-1:0]                 phase,
    output logic                             busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_MAX = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
    localparam int c_CNT_W   = cnt_width(c_CNT_MAX);

    localparam logic [c_CNT_W-1:0] c_GATE_LAST   = c_CNT_W'(GATE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYC - 1);
    localparam logic [DIV_W-1:0]   c_DIV_RST     = DIV_W'(DIV_DEFAULT);
    localparam logic [DIV_W-1:0]   c_MIN_DIV     = DIV_W'(MIN_DIV);

    localparam bit c_PARAM_OK = div_default_ok(DIV_DEFAULT, DIV_W) &&
                                cycle_cnt_ok(GATE_CYC) &&
                                cycle_cnt_ok(SETTLE_CYC);

    // Reject illegal parameter sets at elaboration.
    generate
        if (!c_PARAM_OK) begin : g_bad_param
            $error("jlsemi_util_clkdiv_ratio_ctrl: illegal DIV_DEFAULT/GATE_CYC/SETTLE_CYC");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [DIV_W-1:0]   r_pend;
    logic [DIV_W-1:0]   r_div_ratio;
    logic               r_div_rstn;
    logic               r_gate_en;
    logic               r_ack;
    logic               r_err;
    logic               r_busy;

    logic               w_accept;
    logic               w_div_bad;
    logic               w_div_same;
    logic               w_wrap;
    logic [DIV_W-1:0]   w_phase;

    // ------------------------------------------------------------------------
    // Phase model of the divider
    // ------------------------------------------------------------------------
    jlsemi_util_clkdiv_phase_cnt #(
        .DIV_W (DIV_W)
    ) u_phase_cnt (
        .clk_in_pre (clk_in_pre),
        .rstn_out   (rstn_out),
        .en         (r_gate_en),
        .ratio      (r_div_ratio),
        .clr        (~r_div_rstn),
        .phase      (w_phase),
        .wrap       (w_wrap)
    );

    // ------------------------------------------------------------------------
    // Request classification
    // ------------------------------------------------------------------------
    // A request is only taken from IDLE with ack low, so a request still held
    // high after its ack can never retrigger.
    assign w_accept   = (r_state == c_ST_IDLE) && cfg_if.cfg_req && !r_ack;
    assign w_div_bad  = (cfg_if.cfg_div < c_MIN_DIV);
    assign w_div_same = (cfg_if.cfg_div == r_div_ratio);

    // Next-state decode for the ratio-change sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_INIT: begin
                if (r_cnt == c_SETTLE_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_div_bad || w_div_same) ? c_ST_DONE : c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_wrap) begin
                    w_state_nxt = c_ST_GATE;
                end
            end
            c_ST_GATE: begin
                if (r_cnt == c_GATE_LAST) begin
                    w_state_nxt = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                w_state_nxt = c_ST_SETTLE;
            end
            c_ST_SETTLE: begin
                if (r_cnt == c_SETTLE_LAST) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (r_ack && !cfg_if.cfg_req) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_in_pre or negedge rstn_out) begin
        if (!rstn_out) begin
            r_state <= c_ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dwell counter for the INIT, GATE and SETTLE windows; restarts on every
    // state change so each window is measured from its own entry edge.
    always_ff @(posedge clk_in_pre or negedge rstn_out) begin
        if (!rstn_out) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if ((r_state == c_ST_INIT) || (r_state == c_ST_GATE) ||
                     (r_state == c_ST_SETTLE)) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Capture the requested ratio once, at acceptance; later cfg_div changes
    // have no effect on the transaction in flight.
    always_ff @(posedge clk_in_pre or negedge rstn_out) begin
        if (!rstn_out) begin
            r_pend <= '0;
        end else if (w_accept) begin
            r_pend <= cfg_if.cfg_div;
        end
    end

    // Applied ratio changes on the edge that leaves LOAD.
    always_ff @(posedge clk_in_pre or negedge rstn_out) begin
        if (!rstn_out) begin
            r_div_ratio <= c_DIV_RST;
        end else if (r_state == c_ST_LOAD) begin
            r_div_ratio <= r_pend;
        end
    end

    // Divider soft reset is low for exactly the LOAD cycle and high otherwise,
    // including while rstn_out is asserted.
    always_ff @(posedge clk_in_pre or negedge rstn_out) begin
        if (!rstn_out) begin
            r_div_rstn <= 1'b1;
        end else begin
            r_div_rstn <= !((r_state == c_ST_GATE) && (w_state_nxt == c_ST_LOAD));
        end
    end

    // Clock gate: opens at the end of INIT and SETTLE, closes on the period
    // boundary seen in DRAIN.
    always_ff @(posedge clk_in_pre or negedge rstn_out) begin
        if (!rstn_out) begin
            r_gate_en <= 1'b0;
        end else if ((r_state == c_ST_INIT) && (w_state_nxt == c_ST_IDLE)) begin
            r_gate_en <= 1'b1;
        end else if ((r_state == c_ST_DRAIN) && (w_state_nxt == c_ST_GATE)) begin
            r_gate_en <= 1'b0;
        end else if ((r_state == c_ST_SETTLE) && (w_state_nxt == c_ST_DONE)) begin
            r_gate_en <= 1'b1;
        end
    end

    // Handshake response: ack rises with the re-enabled clock on a ratio
    // change, or one cycle after acceptance for same-ratio/illegal requests;
    // both ack and err clear once the requester drops cfg_req.
    always_ff @(posedge clk_in_pre or negedge rstn_out) begin
        if (!rstn_out) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
        end else if ((r_state == c_ST_SETTLE) && (w_state_nxt == c_ST_DONE)) begin
            r_ack <= 1'b1;
            r_err <= 1'b0;
        end else if ((r_state == c_ST_DONE) && !r_ack) begin
            r_ack <= 1'b1;
            r_err <= (r_pend < c_MIN_DIV);
        end else if ((r_state == c_ST_DONE) && (w_state_nxt == c_ST_IDLE)) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
        end
    end

    // Busy mirrors the state register: high everywhere except IDLE.
    always_ff @(posedge clk_in_pre or negedge rstn_out) begin
        if (!rstn_out) begin
            r_busy <= 1'b1;
        end else begin
            r_busy <= (w_state_nxt != c_ST_IDLE);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cfg_if.cfg_ack = r_ack;
    assign cfg_if.cfg_err = r_err;
    assign div_ratio      = r_div_ratio;
    assign div_rstn       = r_div_rstn;
    assign clk_gate_en    = r_gate_en;
    assign phase          = w_phase;
    assign busy           = r_busy;

endmodule : jlsemi_util_clkdiv_ratio_ctrl
`default_nettype wire

// File: doc/jlsemi_util_clkdiv_ratio_ctrl.md
# jlsemi_util_clkdiv_ratio_ctrl

Runtime ratio controller for the odd/even clock divider. It accepts divide-ratio change requests over a four-phase req/ack handshake and waits for the divided-clock period boundary. It then gates the divided clock, soft-resets the divider, loads the new ratio, settles, and re-enables the clock. It sits beside the divider in the same reset-synchronised clock domain, so glitch-free ratio changes need no software timing.

## Interface
- DIV_W, 8: width of ratio fields.
- DIV_DEFAULT, 5: ratio after reset; must be ≥ 2.
- GATE_CYC, 2: cycles the gate stays off before load; must be ≥ 1.
- SETTLE_CYC, 4: cycles after load before re-enable; must be ≥ 1.

Ports:
- clk_in_pre  in  1  controller and divider input clock.
- rstn_out  in  1  reset, asynchronous, active-low; clock clk_in_pre.
- cfg_req  in  1  ratio change request, level, four-phase.
- cfg_div  in  DIV_W  requested ratio, sampled at acceptance only.
- cfg_ack  out  1  request complete; held high until cfg_req is low.
- cfg_err  out  1  valid with cfg_ack; 1 means the ratio was rejected.
- div_ratio  out  DIV_W  ratio currently applied to the divider.
- div_rstn  out  1  synchronous soft reset to the divider counters, active-low.
- clk_gate_en  out  1  enable to the output clock gate.
- phase  out  DIV_W  divider phase model, 0..div_ratio-1.
- busy  out  1  high in every state except IDLE.

## Operation
- Reset values: div_ratio=DIV_DEFAULT, clk_gate_en=0, div_rstn=1, cfg_ack=0, cfg_err=0, phase=0. The FSM resets to INIT.
- Phase counter: while clk_gate_en=1 it increments and wraps from div_ratio-1 to 0. While clk_gate_en=0 it is held at 0.
- FSM states: INIT, IDLE, DRAIN, GATE, LOAD, SETTLE, DONE.
- INIT: runs SETTLE_CYC cycles, then sets clk_gate_en=1 and goes to IDLE. No ack is produced.
- IDLE: on cfg_req=1 and cfg_ack=0, latch cfg_div into pend.
  - pend<2: go to DONE with err=1.
  - pend==div_ratio: go to DONE with err=0.
  - Otherwise: go to DRAIN.
- DRAIN: when phase==div_ratio-1, clear clk_gate_en and go to GATE.
- GATE: hold for GATE_CYC cycles, then go to LOAD.
- LOAD: lasts one cycle. div_rstn=0 during this cycle. div_ratio<=pend on the exit edge. Then go to SETTLE.
- SETTLE: hold for SETTLE_CYC cycles. On the exit edge, set clk_gate_en=1 and cfg_ack=1, then go to DONE.
- DONE: cfg_ack=1 and cfg_err are held. When cfg_req=0, clear both and go to IDLE.
- Changes to cfg_req or cfg_div after acceptance are ignored until DONE.
- A request held high after ack cannot retrigger; cfg_req must fall first.
- Ratio arithmetic is unsigned DIV_W. pend==0 and pend==1 are both errors.

## Timing
- All outputs are registered. The FSM reads no combinational path from cfg_*.
- Same-ratio or error request: cfg_ack rises on the edge after the acceptance edge. clk_gate_en and div_ratio do not change.
- Ratio change, with W as the edge where DRAIN sees phase==div_ratio-1:
  - clk_gate_en falls at W.
  - LOAD occupies the cycle after edge W+GATE_CYC.
  - div_ratio updates at edge W+GATE_CYC+1.
  - clk_gate_en and cfg_ack rise together at edge W+GATE_CYC+1+SETTLE_CYC.
  - clk_gate_en is therefore low for GATE_CYC+1+SETTLE_CYC cycles.
- DRAIN wait is 0..div_ratio-1 cycles after acceptance.
- After DONE exits, the earliest new acceptance is 1 cycle after cfg_req is seen low.
- Reset asserted mid-operation clears everything immediately to reset values and discards pend. After release the FSM goes INIT→IDLE with no ack.
- div_rstn is never low outside LOAD, including during reset.

## Structure
- Package jlsemi_util_clkdiv_pkg holds:
  - the state enum;
  - MIN_DIV=2;
  - parameter-legality check functions.
- Sub-module jlsemi_util_clkdiv_phase_cnt holds the phase counter. Its inputs are clk_in_pre, rstn_out, en, ratio, and clr. Its outputs are phase and wrap.
- The FSM and the handshake stay in the top module.

## Test plan
- Reset release: clk_gate_en=0 for 4 cycles then 1; div_ratio=5; phase cycles 0..4; cfg_ack stays 0.
- Request div=7: gate falls at the phase==4 edge and stays low 7 cycles. div_rstn is low exactly 1 cycle. div_ratio=7. cfg_ack and gate rise on the same edge, then phase cycles 0..6.
- Request div=1: cfg_ack=1 and cfg_err=1 one cycle after acceptance. div_ratio stays 5 and clk_gate_en stays 1.
- Request div=5 while ratio=5: cfg_ack=1 and cfg_err=0 one cycle after acceptance, with no gating.
- Assert reset during SETTLE of a 5→9 change: outputs return to reset values immediately. After release, INIT lasts 4 cycles, div_ratio=5, and no ack.
- Hold cfg_req high 10 cycles after ack and toggle cfg_div while busy: no second transaction occurs and the changed cfg_div is ignored. After cfg_req falls, ack clears next cycle; a new request is accepted one cycle later.
